text_overlay_ctrl: RTL
======================

Name: text_overlay_ctrl

Overview:
Character-cell text overlay controller that drives the shared 5x8 glyph ROM (`characters`) from VGA pixel coordinates. It holds a writable COLS x ROWS text buffer of ASCII codes and maps each incoming pixel (hc, vc) to a buffer cell, glyph column and glyph row. It sequences the glyph lookup through a 2-stage pipeline and returns the overlay pixel, with an optional blinking cursor. It sits between the VGA sync generator and the colour mux.

Parameters:
COLS, 16, text columns per row
ROWS, 4, text rows; COLS*ROWS <= 256
X0, 0, left edge of text box in pixels
Y0, 0, top edge of text box in pixels
SCALE_LOG2, 0, each glyph pixel drawn as 2^S x 2^S screen pixels
BLINK_CYCLES, 25000000, clock cycles per cursor blink phase

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
hc  in  11  current pixel x from VGA sync
vc  in  11  current pixel y from VGA sync
wr_en  in  1  buffer write strobe
wr_addr  in  8  cell index, row*COLS+col
wr_data  in  8  ASCII code to store
wr_ready  out  1  buffer accepts writes
cursor_en  in  1  enable cursor
cursor_addr  in  8  cursor cell index
glyph_sel  out  8  to characters.select
glyph_x  out  3  to characters.coor_x (0 = leftmost)
glyph_y  out  3  to characters.coor_y (0 = top)
glyph_pixel  in  1  from characters.pixel
text_pixel  out  1  overlay pixel on
text_valid  out  1  pixel lies inside text box

Behaviour:
- One clock domain (clk); rst is synchronous and active-high.
- Reset values: wr_ready=0, glyph_sel=8'h20, glyph_x=0, glyph_y=0, text_pixel=0, text_valid=0, blink phase=0, blink counter=0, FSM=CLEAR with clear_addr=0.
- FSM CLEAR: writes 8'h20 (space) to clear_addr each cycle, then increments it. After writing address N-1 (N=COLS*ROWS), the FSM goes to RUN. CLEAR lasts exactly N cycles after rst deasserts. While rst is high, the FSM stays at clear_addr=0.
- FSM RUN: wr_ready=1. Asserting rst in any state re-enters CLEAR, so the whole buffer is re-blanked.
- Writes: accepted only when wr_en && wr_ready && wr_addr<N. Otherwise they are dropped silently; no queueing.
- Cell geometry: cell is (8<<S) px wide and (8<<S) px tall. rel_x=hc-X0, rel_y=vc-Y0.
- in_box = hc>=X0 && hc<X0+COLS*(8<<S) && vc>=Y0 && vc<Y0+ROWS*(8<<S); comparisons are unsigned, 12-bit.
- col=rel_x>>(3+S), row=rel_y>>(3+S), gx=(rel_x>>S)&7, gy=(rel_y>>S)&7, addr=row*COLS+col.
- Pipeline, with inputs presented in cycle t:
  - Edge ending t: the buffer does a synchronous read of addr; gx, gy, in_box and the cursor-hit flag are registered.
  - Cycle t+1: glyph_sel=read data, glyph_x=gx, glyph_y=gy.
  - Edge ending t+1: text_pixel and text_valid are registered.
  - Latency is exactly 2 cycles; throughput is 1 pixel/cycle.
- Same-cycle write and read of the same address returns the OLD data (read-first).
- text_valid = in_box delayed by 2 cycles, forced to 0 during CLEAR.
- text_pixel = text_valid && (gx<=4 ? glyph_pixel : 0) XOR cursor_hit.
  - gx 5..7 are inter-character spacing and are always 0 before the cursor XOR.
- cursor_hit = cursor_en && blink phase && in_box && addr==cursor_addr. When cursor_addr>=N, no cell is ever hit.
- Blink counter: counts 0..BLINK_CYCLES-1 and wraps to 0. It toggles the phase on wrap, and runs in both FSM states.
- Out-of-box pixels: glyph_x/glyph_y still track gx/gy; glyph_sel is whatever the buffer read returns; text_pixel=0.

Test Plan:
All scenarios use COLS=16, ROWS=4, X0=0, Y0=0, S=0, BLINK_CYCLES=4.
- Release rst -> wr_ready=0 for exactly 64 cycles, then 1. Sweeping all cells gives glyph_sel=8'h20 and text_pixel=0 everywhere.
- Write 8'h48 ('H') to addr 0, then drive vc=0, hc=0..7 on consecutive cycles:
  - glyph_sel=8'h48 one cycle after each input.
  - text_pixel two cycles after each input = 1,0,0,0,1,0,0,0 (row 0 of H = 10001, then spacing).
  - text_valid=1.
- Drive hc=128, vc=0 and hc=0, vc=32 -> text_valid=0 and text_pixel=0 two cycles later.
- Write during CLEAR (cycle 10) -> dropped. Write 'A' to addr 5 in the same cycle that addr 5 is read -> glyph_sel shows 8'h20 on that read and 8'h41 on the next read.
- cursor_en=1, cursor_addr=1, cell 1 blank, scan hc=8..15 continuously:
  - text_pixel alternates 4 cycles all-1, then 4 cycles all-0.
  - cursor_addr=64 -> never inverted.
- In RUN with 'H' at addr 0, pulse rst for 1 cycle -> wr_ready low 64 cycles. Afterwards addr 0 reads 8'h20, and text_pixel is 0 across cell 0.

Source files
------------

// File: rtl/text_overlay_ctrl.sv
// rtl/text_overlay_ctrl.sv - character-cell text overlay driving a shared 5x8 glyph ROM
module text_overlay_ctrl #(
    parameter int COLS         = 16,
    parameter int ROWS         = 4,
    parameter int X0           = 0,
    parameter int Y0           = 0,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        cursor_en,
    input  logic [7:0]  cursor_addr,
    output logic [7:0]  glyph_sel,
    output logic [2:0]  glyph_x,
    output logic [2:0]  glyph_y,
    input  logic        glyph_pixel,
    output logic        text_pixel,
    output logic        text_valid
);

    localparam int N    = COLS * ROWS;
    localparam int CELL = 8 << SCALE_LOG2;
    localparam int BCW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0 + COLS * CELL);
    localparam logic [11:0] Y_LO = 12'(Y0);
    localparam logic [11:0] Y_HI = 12'(Y0 + ROWS * CELL);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q;
    logic [7:0]      clear_addr_q;
    logic            wr_ready_q;

    logic [7:0]      mem_q [0:255];
    logic            mem_we_d;
    logic [7:0]      mem_waddr_d;
    logic [7:0]      mem_wdata_d;

    logic [BCW-1:0]  blink_cnt_q;
    logic            blink_q;

    logic [11:0]     hc_w;
    logic [11:0]     vc_w;
    logic [11:0]     rel_x;
    logic [11:0]     rel_y;
    logic [11:0]     col;
    logic [11:0]     row;
    logic [7:0]      pix_addr;
    logic [2:0]      gx_d;
    logic [2:0]      gy_d;
    logic            in_box_d;
    logic            cursor_hit_d;

    logic [7:0]      glyph_sel_q;
    logic [2:0]      gx_q;
    logic [2:0]      gy_q;
    logic            in_box_q;
    logic            hit_q;
    logic            text_pixel_q;
    logic            text_valid_q;

    // Blanks the buffer one cell per cycle after reset, then opens the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= 8'd0;
            wr_ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clear_addr_q <= clear_addr_q + 8'd1;
                    if (clear_addr_q == 8'(N - 1)) begin
                        state_q      <= ST_RUN;
                        clear_addr_q <= 8'd0;
                        wr_ready_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    wr_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = clear_addr_q;
        mem_wdata_d = 8'h20;
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_we_d = 1'b1;
            end else if (wr_en && wr_ready_q && (32'(wr_addr) < N)) begin
                mem_we_d    = 1'b1;
                mem_waddr_d = wr_addr;
                mem_wdata_d = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BCW'(BLINK_CYCLES - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign hc_w     = {1'b0, hc};
    assign vc_w     = {1'b0, vc};
    assign rel_x    = hc_w - X_LO;
    assign rel_y    = vc_w - Y_LO;
    assign in_box_d = (hc_w >= X_LO) && (hc_w < X_HI) && (vc_w >= Y_LO) && (vc_w < Y_HI);
    assign col      = rel_x >> (3 + SCALE_LOG2);
    assign row      = rel_y >> (3 + SCALE_LOG2);
    assign gx_d     = 3'(rel_x >> SCALE_LOG2);
    assign gy_d     = 3'(rel_y >> SCALE_LOG2);
    assign pix_addr = 8'(32'(row) * COLS + 32'(col));

    assign cursor_hit_d = cursor_en && blink_q && in_box_d &&
                          (pix_addr == cursor_addr) && (32'(cursor_addr) < N);

    // Stage 1: buffer read is read-first, so a same-cycle write shows up one pixel later.
    always_ff @(posedge clk) begin
        if (rst) begin
            glyph_sel_q <= 8'h20;
            gx_q        <= 3'd0;
            gy_q        <= 3'd0;
            in_box_q    <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            glyph_sel_q <= mem_q[pix_addr];
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            in_box_q    <= in_box_d;
            hit_q       <= cursor_hit_d;
        end
    end

    // Stage 2: glyph columns 5..7 are inter-character spacing and never light up.
    always_ff @(posedge clk) begin
        if (rst) begin
            text_valid_q <= 1'b0;
            text_pixel_q <= 1'b0;
        end else begin
            text_valid_q <= in_box_q && (state_q == ST_RUN);
            text_pixel_q <= in_box_q && (state_q == ST_RUN) &&
                            (((gx_q <= 3'd4) && glyph_pixel) ^ hit_q);
        end
    end

    assign wr_ready   = wr_ready_q;
    assign glyph_sel  = glyph_sel_q;
    assign glyph_x    = gx_q;
    assign glyph_y    = gy_q;
    assign text_pixel = text_pixel_q;
    assign text_valid = text_valid_q;

endmodule
